// File: rtl/javk_busctl.sv
// JAVK memory bus controller: arbitrates fetch and load/store ports onto
// one 8-bit bus, splitting 16-bit transfers into two little-endian byte cycles.
module javk_busctl #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        f_wide,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic        d_wide,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    input  logic [7:0]  datain,
    output logic [15:0] addrbus,
    output logic        rw,
    output logic [7:0]  dataout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    // port_q / last_q: 1 = data port, 0 = fetch port
    logic        port_q;
    logic        last_q;
    logic        wide_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;
    logic [15:0] addr_last_q;
    logic [15:0] f_rdata_q;
    logic [15:0] d_rdata_q;
    logic        f_ack_q;
    logic        d_ack_q;
    logic        busy_q;

    logic        any_req;
    logic        pick_data;
    logic [15:0] addr_inc;
    logic        rd_wr;
    logic [15:0] rd_val;

    assign any_req  = f_req | d_req;
    assign addr_inc = addr_q + 16'd1;

    // Data wins a tie unless round-robin says fetch is owed the bus.
    always_comb begin
        pick_data = 1'b0;
        if (d_req) begin
            pick_data = !f_req || !FAIR || !last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (any_req) state_d = S_LO;
            S_LO:   state_d = wide_q ? S_HI : S_ACK;
            S_HI:   state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addrbus = addr_last_q;
        rw      = 1'b0;
        dataout = 8'h00;
        unique case (state_q)
            S_LO: begin
                addrbus = addr_q;
                rw      = we_q;
                dataout = wdata_q[7:0];
            end
            S_HI: begin
                addrbus = addr_inc;
                rw      = we_q;
                dataout = wdata_q[15:8];
            end
            S_IDLE, S_ACK: begin
                addrbus = addr_last_q;
            end
        endcase
    end

    // Port rdata only changes on the final byte so it stays stable until ack.
    always_comb begin
        rd_wr  = 1'b0;
        rd_val = 16'h0000;
        if (!we_q) begin
            if (state_q == S_LO && !wide_q) begin
                rd_wr  = 1'b1;
                rd_val = {8'h00, datain};
            end else if (state_q == S_HI) begin
                rd_wr  = 1'b1;
                rd_val = {datain, lo_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            port_q      <= 1'b0;
            last_q      <= 1'b0;
            wide_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            lo_q        <= 8'h00;
            addr_last_q <= 16'h0000;
            f_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            f_ack_q <= (state_d == S_ACK) && !port_q;
            d_ack_q <= (state_d == S_ACK) && port_q;

            if (state_q == S_IDLE && any_req) begin
                port_q  <= pick_data;
                addr_q  <= pick_data ? d_addr : f_addr;
                wide_q  <= pick_data ? d_wide : f_wide;
                we_q    <= pick_data & d_we;
                wdata_q <= pick_data ? d_wdata : 16'h0000;
            end

            if (state_q == S_LO) begin
                addr_last_q <= addr_q;
                lo_q        <= datain;
            end
            if (state_q == S_HI) begin
                addr_last_q <= addr_inc;
            end

            if (rd_wr) begin
                if (port_q) d_rdata_q <= rd_val;
                else        f_rdata_q <= rd_val;
            end

            if (state_q == S_ACK) begin
                last_q <= port_q;
            end
        end
    end

    assign f_ack   = f_ack_q;
    assign d_ack   = d_ack_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_javk_busctl.sv
// Scoreboard bench for javk_busctl: expected acks/writes are queued by the
// stimulus and retired by a monitor that watches the DUT outputs.
module tb_javk_busctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_wide, d_req, d_we, d_wide;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, rw, busy;
    logic [15:0] f_rdata, d_rdata, addrbus;
    logic [7:0]  datain, dataout;

    logic        x_f_req, x_d_req;
    logic        x_f_ack, x_d_ack, x_rw, x_busy;
    logic [15:0] x_f_rdata, x_d_rdata, x_addrbus;
    logic [7:0]  x_datain, x_dataout;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } ack_t;
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    ack_t aq[$];
    wr_t  wq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rdb(logic [15:0] a);
        case (a)
            16'h1234: rdb = 8'hA5;
            16'hFFFF: rdb = 8'h34;
            16'h0000: rdb = 8'h12;
            16'h2000: rdb = 8'h5A;
            16'h2001: rdb = 8'hC3;
            16'h3000: rdb = 8'h77;
            16'h4000: rdb = 8'h88;
            default:  rdb = 8'hEE;
        endcase
    endfunction

    assign datain   = rdb(addrbus);
    assign x_datain = rdb(x_addrbus);

    javk_busctl #(.FAIR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_wide(f_wide),
        .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wide(d_wide),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .datain(datain), .addrbus(addrbus), .rw(rw),
        .dataout(dataout), .busy(busy)
    );

    javk_busctl #(.FAIR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .f_req(x_f_req), .f_addr(16'h3000), .f_wide(1'b0),
        .f_ack(x_f_ack), .f_rdata(x_f_rdata),
        .d_req(x_d_req), .d_we(1'b0), .d_addr(16'h4000), .d_wide(1'b0),
        .d_wdata(16'h0000), .d_ack(x_d_ack), .d_rdata(x_d_rdata),
        .datain(x_datain), .addrbus(x_addrbus), .rw(x_rw),
        .dataout(x_dataout), .busy(x_busy)
    );

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: retire expected acks and bus writes as the DUT shows them.
    always @(negedge clk) begin
        if (f_ack === 1'b1 || d_ack === 1'b1) begin
            check("ack_excl", 16'(f_ack & d_ack), 16'h0);
            if (aq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: f=%b d=%b want none", f_ack, d_ack);
            end else begin
                ack_t e;
                e = aq.pop_front();
                check("ack_port", 16'(d_ack), 16'(e.port));
                check("ack_rdata", d_ack ? d_rdata : f_rdata, e.rdata);
            end
        end
        if (rw === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h want none", addrbus);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", addrbus, w.a);
                check("wr_data", 16'(dataout), 16'(w.d));
            end
        end
    end

    task automatic xfer(bit port, bit we, logic [15:0] addr, bit wide,
                        logic [15:0] wdata, logic [15:0] exp_rd);
        logic [15:0] ahi;
        ahi = 16'(addr + 16'd1);
        aq.push_back('{port, exp_rd});
        if (we) begin
            wq.push_back('{addr, wdata[7:0]});
            if (wide) wq.push_back('{ahi, wdata[15:8]});
        end
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr;
            d_wide = wide; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr; f_wide = wide;
        end
        @(negedge clk);
        check("lo_addr", addrbus, addr);
        check("lo_rw", 16'(rw), 16'(we));
        check("lo_busy", 16'(busy), 16'h1);
        check("lo_dout", 16'(dataout), we ? 16'(wdata[7:0]) : 16'h0);
        if (wide) begin
            @(negedge clk);
            check("hi_addr", addrbus, ahi);
            check("hi_dout", 16'(dataout), we ? 16'(wdata[15:8]) : 16'h0);
        end
        @(negedge clk);
        check("ack_lat", 16'(port ? d_ack : f_ack), 16'h1);
        check("ack_rw", 16'(rw), 16'h0);
        f_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("idle_busy", 16'(busy), 16'h0);
    endtask

    initial begin
        int seen;
        int last;
        int xd;
        int xf;
        rst = 1'b1;
        f_req = 0; f_wide = 0; f_addr = 0;
        d_req = 0; d_we = 0; d_wide = 0; d_addr = 0; d_wdata = 0;
        x_f_req = 0; x_d_req = 0;
        repeat (2) @(negedge clk);
        check("rst_addr", addrbus, 16'h0000);
        check("rst_rw", 16'(rw), 16'h0);
        check("rst_dout", 16'(dataout), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_acks", 16'({f_ack, d_ack}), 16'h0);
        check("rst_frd", f_rdata, 16'h0000);
        check("rst_drd", d_rdata, 16'h0000);
        check("rst_x_bus", x_addrbus | 16'({x_rw, x_busy, x_dataout}), 16'h0);
        check("rst_x_rd", x_f_rdata | x_d_rdata, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        xfer(1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h00A5);
        xfer(1'b1, 1'b0, 16'h2000, 1'b1, 16'h0000, 16'hC35A);
        xfer(1'b1, 1'b1, 16'h8000, 1'b1, 16'hBEEF, 16'hC35A);
        xfer(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 16'h00A5);
        xfer(1'b0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 16'h1234);

        // Round-robin with both ports held high; last grant was fetch.
        aq.push_back('{1'b1, 16'h0088});
        aq.push_back('{1'b0, 16'h0077});
        aq.push_back('{1'b1, 16'h0088});
        aq.push_back('{1'b0, 16'h0077});
        f_addr = 16'h3000; f_wide = 0;
        d_addr = 16'h4000; d_wide = 0; d_we = 0;
        f_req = 1; d_req = 1;
        seen = 0;
        last = 0;
        for (int c = 1; c <= 20 && seen < 4; c++) begin
            @(negedge clk);
            if (f_ack || d_ack) begin
                seen++;
                if (seen > 1) check("arb_gap", 16'(c - last), 16'd3);
                last = c;
                if (seen == 4) begin
                    f_req = 0;
                    d_req = 0;
                end
            end
        end
        check("arb_count", 16'(seen), 16'd4);
        @(negedge clk);

        // Fixed priority: data takes every grant while it keeps requesting.
        x_f_req = 1; x_d_req = 1;
        xd = 0;
        xf = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (x_d_ack) xd++;
            if (x_f_ack) xf++;
            if (c == 9) x_d_req = 0;
        end
        x_f_req = 0;
        check("fix_dacks", 16'(xd), 16'd3);
        check("fix_facks", 16'(xf), 16'd0);
        check("fix_drd", x_d_rdata, 16'h0088);
        check("fix_rw", 16'({x_rw, x_dataout}), 16'h0);
        @(negedge clk);

        // Reset during HI of a wide read: no ack, everything cleared.
        d_we = 0; d_addr = 16'h2000; d_wide = 1; d_req = 1;
        repeat (2) @(negedge clk);
        check("mid_hi_addr", addrbus, 16'h2001);
        rst = 1;
        d_req = 0;
        @(negedge clk);
        check("mid_rw", 16'(rw), 16'h0);
        check("mid_addr", addrbus, 16'h0000);
        check("mid_busy", 16'(busy), 16'h0);
        check("mid_ack", 16'({f_ack, d_ack}), 16'h0);
        check("mid_rd", f_rdata | d_rdata, 16'h0000);
        rst = 0;
        @(negedge clk);
        check("post_ack", 16'({f_ack, d_ack}), 16'h0);
        xfer(1'b1, 1'b0, 16'h2000, 1'b1, 16'h0000, 16'hC35A);

        repeat (2) @(negedge clk);
        check("sb_acks_left", 16'(aq.size()), 16'd0);
        check("sb_wrs_left", 16'(wq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/javk_busctl.md
# javk_busctl

Memory bus controller for the JAVK CPU. Two internal requesters share the single 8-bit external memory bus: the instruction fetch port and the load/store data port. The block arbitrates between them and splits 16-bit transfers into two little-endian byte cycles. It drives `addrbus`, `rw` and write data; the CPU top owns the `databus` tristate.

## Interface
- `FAIR`, default 1: 1 = round-robin on simultaneous requests; 0 = data port has fixed priority.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `f_req`  in  1  fetch request; hold high until `f_ack`.
- `f_addr`  in  16  fetch byte address.
- `f_wide`  in  1  1 = 16-bit read, 0 = 8-bit read.
- `f_ack`  out  1  one-cycle completion pulse for the fetch port.
- `f_rdata`  out  16  fetch read data; `[15:8]` = 0 for byte reads.
- `d_req`  in  1  data request; hold high until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  16  data byte address.
- `d_wide`  in  1  1 = 16-bit, 0 = 8-bit.
- `d_wdata`  in  16  write data; low byte goes to `d_addr`.
- `d_ack`  out  1  one-cycle completion pulse for the data port.
- `d_rdata`  out  16  data read data; unchanged by writes.
- `datain`  in  8  byte sampled from the bus.
- `addrbus`  out  16  external address.
- `rw`  out  1  1 = write cycle (top drives `databus`), 0 = read/idle.
- `dataout`  out  8  write byte.
- `busy`  out  1  high in LO, HI and ACK.

## Operation
- States: IDLE, LO, HI, ACK.
- IDLE, arbitration:
  - Requests are sampled only in IDLE.
  - Single request: that port is granted.
  - Both requesting, `FAIR=1`: the port not granted last wins. The last-grant register resets to "fetch", so the first tie goes to data.
  - Both requesting, `FAIR=0`: data wins.
  - On grant, latch port id, addr, wide, we and wdata (we = 0 for fetch), then go to LO.
- LO:
  - `addrbus` = addr; `rw` = we; `dataout` = wdata[7:0].
  - Reads capture `datain` into the low byte of the port's rdata at the end of the cycle.
  - Next state: HI if wide, else ACK.
- HI:
  - `addrbus` = addr+1, 16-bit modulo (0xFFFF wraps to 0x0000); `dataout` = wdata[15:8].
  - Reads capture `datain` into rdata[15:8].
  - Next state: ACK.
- ACK:
  - Granted port's ack = 1 for exactly this cycle; its rdata is final and is held until that port's next read completes.
  - Update the last-grant register, then go to IDLE.
- Byte reads clear rdata[15:8] at completion.
- Outside LO/HI: `rw` = 0 and `dataout` = 0; `addrbus` holds its last value.
- A requester dropping req mid-transfer does not abort it; the transfer completes and ack still pulses.
- Latched payload is used throughout, so input changes after grant have no effect.

## Timing
- Reset values:
  - `state` = IDLE.
  - `addrbus` = 0x0000; `rw` = 0; `dataout` = 0x00.
  - `f_ack` = 0; `d_ack` = 0.
  - `f_rdata` = 0x0000; `d_rdata` = 0x0000.
  - `busy` = 0; last-grant = fetch.
- Reset mid-transfer: the next cycle is IDLE with all reset values; no ack for the aborted transfer; rdata cleared.
- Latency, counted from the IDLE cycle in which req is sampled high (cycle 0):
  - Byte: LO in cycle 1, ack in cycle 2.
  - Wide: LO in 1, HI in 2, ack in 3.
- Throughput: a requester may keep req high through ack. It is resampled in the IDLE cycle after ack, so back-to-back byte transfers occur every 3 cycles.
- `busy` is registered and tracks state exactly; `f_ack` and `d_ack` are never high together.

## Test plan
- Byte read: `f_req`=1, `f_addr`=0x1234, `f_wide`=0, `datain`=0xA5 in LO → `addrbus`=0x1234 in cycle 1, `f_ack` in cycle 2, `f_rdata`=0x00A5, `rw`=0 throughout.
- Wide write: `d_we`=1, `d_addr`=0x8000, `d_wdata`=0xBEEF → LO: addr 0x8000, `rw`=1, `dataout`=0xEF; HI: addr 0x8001, `dataout`=0xBE; `d_ack` in cycle 3; `d_rdata` unchanged.
- Wrap-around: wide fetch at 0xFFFF with `datain` 0x34 then 0x12 → HI `addrbus`=0x0000, `f_rdata`=0x1234.
- Arbitration, `FAIR`=1, both ports requesting continuously → grants in order data, fetch, data, fetch, each ack 3 cycles apart for byte ops. With `FAIR`=0 → data every time while `d_req` stays high.
- Reset mid-op: assert `rst` during HI of a wide read → next cycle IDLE, `rw`=0, `addrbus`=0, no ack, rdata=0; a new request afterwards completes normally.
